// File: rtl/prog_loader.sv
// prog_loader: writer side of the picoMIPS program memory.
// Packs an incoming byte stream (valid/ready) into Isize-bit words, MSB first,
// and writes them to program-memory addresses 0 .. (1<<Psize)-1. The CPU is held
// in reset while a load is in progress, and done flags a complete image.
// Optional feature: define PROG_LOADER_CHKSUM_EN to expect one trailing checksum
// byte C after the image. err is set when (sum of all bytes + C) mod 256 != 0.
// Isize must be at least 9, so that the shift register holding earlier bytes is
// non-empty.

module prog_loader #(
    parameter int unsigned Psize = 6,
    parameter int unsigned Isize = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             we,
    output logic [Psize-1:0] waddr,
    output logic [Isize-1:0] wdata,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             err
);

    localparam int unsigned NB = (Isize + 7) / 8;
    localparam int unsigned BW = $clog2(NB + 1);
    localparam logic [BW-1:0]    BLAST = BW'(NB - 1);
    localparam logic [Psize-1:0] ATOP  = {Psize{1'b1}};

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StWrite,
        StCheck,
        StDone
    } state_e;

    state_e           state;
    logic [BW-1:0]    bcnt;
    // Earlier bytes of the current word. The top bits of the first byte shift out
    // naturally when Isize is not a multiple of 8.
    logic [Isize-9:0] shreg;
    logic [Isize-1:0] shnext;
    logic             xfer;

    assign shnext   = {shreg, rx_data};
    assign xfer     = rx_valid && rx_ready;
    assign cpu_hold = busy;

`ifdef PROG_LOADER_CHKSUM_EN
    logic [7:0] sum8;
    logic       err_q;
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    // Loader FSM: every output is registered and updated together with the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= StIdle;
            rx_ready <= 1'b0;
            we       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            waddr    <= '0;
            wdata    <= '0;
            shreg    <= '0;
            bcnt     <= '0;
`ifdef PROG_LOADER_CHKSUM_EN
            sum8     <= 8'd0;
            err_q    <= 1'b0;
`endif
        end else begin
            case (state)
                StIdle, StDone: begin
                    if (start) begin
                        waddr    <= '0;
                        bcnt     <= '0;
                        done     <= 1'b0;
                        busy     <= 1'b1;
                        rx_ready <= 1'b1;
                        state    <= StLoad;
`ifdef PROG_LOADER_CHKSUM_EN
                        sum8     <= 8'd0;
                        err_q    <= 1'b0;
`endif
                    end
                end

                StLoad: begin
                    if (xfer) begin
                        shreg <= shnext[Isize-9:0];
                        bcnt  <= bcnt + 1'b1;
`ifdef PROG_LOADER_CHKSUM_EN
                        sum8  <= sum8 + rx_data;
`endif
                        if (bcnt == BLAST) begin
                            wdata    <= shnext;
                            we       <= 1'b1;
                            rx_ready <= 1'b0;
                            state    <= StWrite;
                        end
                    end
                end

                StWrite: begin
                    // Single write cycle; the address never wraps past the top.
                    we   <= 1'b0;
                    bcnt <= '0;
                    if (waddr == ATOP) begin
`ifdef PROG_LOADER_CHKSUM_EN
                        rx_ready <= 1'b1;
                        state    <= StCheck;
`else
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= StDone;
`endif
                    end else begin
                        waddr    <= waddr + 1'b1;
                        rx_ready <= 1'b1;
                        state    <= StLoad;
                    end
                end

`ifdef PROG_LOADER_CHKSUM_EN
                StCheck: begin
                    if (xfer) begin
                        err_q    <= ((sum8 + rx_data) != 8'd0);
                        rx_ready <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        state    <= StDone;
                    end
                end
`endif

                default: begin
                    rx_ready <= 1'b0;
                    we       <= 1'b0;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    state    <= StIdle;
                end
            endcase
        end
    end

endmodule
